// File: rtl/plab4_net_router_input_unit.sv
// Buffered greedy-routing input unit for one plab4 ring router port.
// Optional stall counter output enabled by PLAB4_NET_ROUTER_INPUT_UNIT_STATS_EN.
module plab4_net_router_input_unit #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_msg_nbits   = 44,
  parameter int p_dest_lsb    = 38,
  parameter int p_num_entries = 2,
  localparam int c_cnt_nbits  = $clog2(p_num_entries + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic [2:0]             reqs,
  input  logic [2:0]             grants,
`ifdef PLAB4_NET_ROUTER_INPUT_UNIT_STATS_EN
  output logic [15:0]            stall_cycles,
`endif
  output logic [c_cnt_nbits-1:0] num_free
);

  localparam int c_dest_nbits = $clog2(p_num_routers);
  // Two spare bits keep the distance arithmetic exact even for illegal dests.
  localparam int c_dist_nbits = c_dest_nbits + 2;
  localparam int c_ptr_nbits  = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

  localparam logic [c_dist_nbits-1:0] c_id_w   = c_dist_nbits'(p_router_id);
  localparam logic [c_dist_nbits-1:0] c_n_w    = c_dist_nbits'(p_num_routers);
  localparam logic [c_cnt_nbits-1:0]  c_depth  = c_cnt_nbits'(p_num_entries);
  localparam logic [c_ptr_nbits-1:0]  c_ptr_max = c_ptr_nbits'(p_num_entries - 1);

  function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] ptr);
    if (ptr == c_ptr_max) begin
      return {c_ptr_nbits{1'b0}};
    end else begin
      return ptr + c_ptr_nbits'(1);
    end
  endfunction

  logic [p_msg_nbits-1:0]  mem_r [p_num_entries];
  logic [c_ptr_nbits-1:0]  head_r;
  logic [c_ptr_nbits-1:0]  tail_r;
  logic [c_cnt_nbits-1:0]  count_r;
  logic [c_cnt_nbits-1:0]  count_nxt_s;
  logic [c_cnt_nbits-1:0]  num_free_r;
  logic                    tie_r;

  logic                    full_s;
  logic                    empty_s;
  logic                    enq_s;
  logic                    deq_s;
  logic [p_msg_nbits-1:0]  head_s;
  logic [c_dist_nbits-1:0] dest_s;
  logic [c_dist_nbits-1:0] fwd_s;
  logic [c_dist_nbits-1:0] bwd_s;
  logic                    is_tie_s;
  logic [2:0]              reqs_s;

  assign full_s  = (count_r == c_depth);
  assign empty_s = (count_r == {c_cnt_nbits{1'b0}});
  assign head_s  = mem_r[head_r];
  assign enq_s   = in_val && !full_s;
  assign deq_s   = !empty_s && ((reqs_s & grants) != 3'b000);

  assign in_rdy   = !full_s;
  assign out_msg  = head_s;
  assign reqs     = reqs_s;
  assign num_free = num_free_r;

  // Shortest-path route for the head message, tie broken by tie_r.
  always_comb begin
    dest_s   = c_dist_nbits'(head_s[p_dest_lsb +: c_dest_nbits]);
    fwd_s    = {c_dist_nbits{1'b0}};
    bwd_s    = {c_dist_nbits{1'b0}};
    is_tie_s = 1'b0;
    reqs_s   = 3'b000;
    if (dest_s >= c_id_w) begin
      fwd_s = dest_s - c_id_w;
    end else begin
      fwd_s = dest_s + c_n_w - c_id_w;
    end
    bwd_s    = c_n_w - fwd_s;
    is_tie_s = (fwd_s == bwd_s);
    if (empty_s) begin
      reqs_s = 3'b000;
    end else if (fwd_s == {c_dist_nbits{1'b0}}) begin
      reqs_s = 3'b010;
    end else if (fwd_s < bwd_s) begin
      reqs_s = 3'b100;
    end else if (fwd_s > bwd_s) begin
      reqs_s = 3'b001;
    end else begin
      reqs_s = tie_r ? 3'b001 : 3'b100;
    end
  end

  // Occupancy after this edge.
  always_comb begin
    count_nxt_s = count_r;
    if (enq_s && !deq_s) begin
      count_nxt_s = count_r + c_cnt_nbits'(1);
    end else if (deq_s && !enq_s) begin
      count_nxt_s = count_r - c_cnt_nbits'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO control state: pointers, occupancy, free count and tie-break.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r     <= {c_ptr_nbits{1'b0}};
      tail_r     <= {c_ptr_nbits{1'b0}};
      count_r    <= {c_cnt_nbits{1'b0}};
      num_free_r <= c_depth;
      tie_r      <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      num_free_r <= c_depth - count_nxt_s;
      if (enq_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (deq_s) begin
        head_r <= ptr_inc(head_r);
        if (is_tie_s) begin
          tie_r <= !tie_r;
        end
      end
    end
  end

  // Message storage; written at the tail on enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < p_num_entries; i++) begin
        mem_r[i] <= {p_msg_nbits{1'b0}};
      end
    end else if (enq_s) begin
      mem_r[tail_r] <= in_msg;
    end
  end

`ifdef PLAB4_NET_ROUTER_INPUT_UNIT_STATS_EN
  logic [15:0] stall_cycles_r;
  assign stall_cycles = stall_cycles_r;

  // Saturating count of cycles with a pending request that was not granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_r <= 16'h0000;
    end else if ((reqs_s != 3'b000) && !deq_s && (stall_cycles_r != 16'hFFFF)) begin
      stall_cycles_r <= stall_cycles_r + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_plab4_net_router_input_unit.sv
// Self-checking bench: directed test plan plus randomized traffic against a queue model.
module tb_plab4_net_router_input_unit;

  localparam int ID   = 2;
  localparam int N    = 8;
  localparam int MW   = 44;
  localparam int LSB  = 38;
  localparam int DW   = 3;
  localparam int DEP  = 2;

  logic          clk;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [MW-1:0] in_msg;
  logic [MW-1:0] out_msg;
  logic [2:0]    reqs;
  logic [2:0]    grants;
  logic [1:0]    num_free;
`ifdef PLAB4_NET_ROUTER_INPUT_UNIT_STATS_EN
  logic [15:0]   stall_cycles;
`endif

  plab4_net_router_input_unit #(
    .p_router_id   (ID),
    .p_num_routers (N),
    .p_msg_nbits   (MW),
    .p_dest_lsb    (LSB),
    .p_num_entries (DEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .out_msg  (out_msg),
    .reqs     (reqs),
    .grants   (grants),
`ifdef PLAB4_NET_ROUTER_INPUT_UNIT_STATS_EN
    .stall_cycles (stall_cycles),
`endif
    .num_free (num_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [MW-1:0] q[$];
  logic          m_tie;
  int            m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dist_fwd(input int dest);
    return ((dest - ID) % N + N) % N;
  endfunction

  function automatic logic [2:0] ref_route(input int dest, input logic tie);
    int f = dist_fwd(dest);
    int b = N - f;
    if (f == 0) return 3'b010;
    if (f < b)  return 3'b100;
    if (f > b)  return 3'b001;
    return tie ? 3'b001 : 3'b100;
  endfunction

  function automatic int msg_dest(input logic [MW-1:0] m);
    return int'(m[LSB +: DW]);
  endfunction

  function automatic logic [MW-1:0] mk_msg(input int dest);
    logic [63:0]   r;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    r = {$urandom, $urandom};
    m = r[MW-1:0];
    d = DW'(dest);
    m[LSB +: DW] = d;
    return m;
  endfunction

  function automatic logic [2:0] model_reqs();
    if (q.size() == 0) return 3'b000;
    return ref_route(msg_dest(q[0]), m_tie);
  endfunction

  // One cycle: drive after the falling edge, check model, advance model at the rising edge.
  task automatic step(input logic v, input logic [MW-1:0] m, input logic [2:0] g);
    logic [2:0]    er;
    logic          dq;
    logic          ac;
    logic [MW-1:0] h;
    in_val = v;
    in_msg = m;
    grants = g;
    #1;
    er = model_reqs();
    check("in_rdy", 64'(in_rdy), 64'(q.size() < DEP));
    check("reqs", 64'(reqs), 64'(er));
    check("num_free", 64'(num_free), 64'(DEP - q.size()));
    if (q.size() > 0) begin
      h = q[0];
      check("out_msg", 64'(out_msg), 64'(h));
    end
`ifdef PLAB4_NET_ROUTER_INPUT_UNIT_STATS_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    dq = (q.size() > 0) && ((er & g) != 3'b000);
    ac = v && (q.size() < DEP);
    @(posedge clk);
    if (dq) begin
      h = q.pop_front();
      if (dist_fwd(msg_dest(h)) * 2 == N) m_tie = ~m_tie;
    end
    if (ac) q.push_back(m);
    if (er != 3'b000 && !dq && m_stall < 65535) m_stall++;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, {MW{1'b0}}, 3'b111);
  endtask

  logic [MW-1:0] m1, m2, m3;
  int            dests[5] = '{1, 2, 3, 5, 7};
  logic [2:0]    exp_r[5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001};

  initial begin
    reset   = 1'b0;
    in_val  = 1'b0;
    in_msg  = {MW{1'b0}};
    grants  = 3'b000;
    m_tie   = 1'b0;
    m_stall = 0;
    @(negedge clk);
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'(1));
    check("rst_reqs", 64'(reqs), 64'(0));
    check("rst_num_free", 64'(num_free), 64'(DEP));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Idle after reset.
    repeat (5) step(1'b0, {MW{1'b0}}, 3'b000);

    // Greedy routing, one message at a time, grant every cycle.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk_msg(dests[i]), 3'b111);
      check($sformatf("route_d%0d", dests[i]), 64'(reqs), 64'(exp_r[i]));
      step(1'b0, {MW{1'b0}}, 3'b111);
      check("route_clear", 64'(reqs), 64'(0));
    end

    // Tie-break at distance N/2: alternate directions across dequeues.
    step(1'b1, mk_msg(6), 3'b000);
    check("tie_first", 64'(reqs), 64'(3'b100));
    step(1'b0, {MW{1'b0}}, 3'b111);
    step(1'b1, mk_msg(6), 3'b000);
    check("tie_second", 64'(reqs), 64'(3'b001));
    step(1'b0, {MW{1'b0}}, 3'b010);
    check("tie_wrong_grant_reqs", 64'(reqs), 64'(3'b001));
    check("tie_wrong_grant_free", 64'(num_free), 64'(1));
    step(1'b0, {MW{1'b0}}, 3'b111);
    step(1'b1, mk_msg(6), 3'b000);
    check("tie_third", 64'(reqs), 64'(3'b100));
    drain();

    // Full FIFO and backpressure.
    m1 = mk_msg(3);
    m2 = mk_msg(4);
    m3 = mk_msg(0);
    step(1'b1, m1, 3'b000);
    step(1'b1, m2, 3'b000);
    check("full_in_rdy", 64'(in_rdy), 64'(0));
    check("full_num_free", 64'(num_free), 64'(0));
    step(1'b1, m3, 3'b000);
    check("full_head", 64'(out_msg), 64'(m1));
    step(1'b1, m3, 3'b111);
    check("after_grant_in_rdy", 64'(in_rdy), 64'(1));
    check("after_grant_head", 64'(out_msg), 64'(m2));
    step(1'b1, m3, 3'b000);
    check("third_accepted", 64'(num_free), 64'(0));
    drain();

    // Simultaneous enqueue and dequeue with one entry occupied.
    m1 = mk_msg(5);
    m2 = mk_msg(1);
    step(1'b1, m1, 3'b000);
    step(1'b1, m2, 3'b111);
    check("simul_num_free", 64'(num_free), 64'(1));
    check("simul_head", 64'(out_msg), 64'(m2));
    drain();

    // Asynchronous reset pulse between edges with two messages queued.
    step(1'b1, mk_msg(7), 3'b000);
    step(1'b1, mk_msg(3), 3'b000);
    step(1'b0, {MW{1'b0}}, 3'b000);
    in_val = 1'b0;
    grants = 3'b000;
    reset  = 1'b0;
    #1;
    check("arst_reqs", 64'(reqs), 64'(0));
    check("arst_in_rdy", 64'(in_rdy), 64'(1));
    check("arst_num_free", 64'(num_free), 64'(DEP));
`ifdef PLAB4_NET_ROUTER_INPUT_UNIT_STATS_EN
    check("arst_stall", 64'(stall_cycles), 64'(0));
`endif
    #1;
    reset = 1'b1;
    q.delete();
    m_tie   = 1'b0;
    m_stall = 0;
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), mk_msg(int'($urandom_range(0, N - 1))),
           3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/plab4_net_router_input_unit.md
Name: plab4_net_router_input_unit

Overview:
Buffered, greedy-routing input unit for one router port on the plab4 bidirectional ring. It queues incoming messages in a small FIFO, computes a one-hot output-port request for the head message using shortest-path routing with alternating tie-break, and dequeues the head when the switch allocator grants the requested port. It replaces the bufferless pass-through input control at each router input; one instance per input port.

Parameters:
p_router_id, 0, id of this router, 0..p_num_routers-1
p_num_routers, 8, ring size, >=2, need not be a power of two
p_msg_nbits, 44, message width
p_dest_lsb, 38, LSB of dest field in message; field width d = clog2(p_num_routers)
p_num_entries, 2, FIFO depth, >=1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_val  in  1  upstream message valid
in_rdy  out  1  FIFO can accept (= not full)
in_msg  in  p_msg_nbits  upstream message
out_msg  out  p_msg_nbits  head message, drives crossbar input
reqs  out  3  one-hot request for head: [2] = increasing-id direction, [1] = terminal, [0] = decreasing-id direction
grants  in  3  allocator grants for this input
num_free  out  clog2(p_num_entries+1)  free FIFO entries

Behaviour:
- Reset (reset low, async): FIFO empty, head/tail pointers 0, tie-break reg 0. Outputs: in_rdy=1, reqs=000, num_free=p_num_entries, out_msg don't-care.
- Enqueue when in_val && in_rdy at posedge. in_rdy = !full only; no same-cycle pass-through when full, so there is no combinational path from grants to in_rdy.
- Enqueue-to-request latency: 1 cycle. reqs appears the cycle after the accepting edge. No bypass.
- Route for head dest D: f = (D - p_router_id) mod p_num_routers, with no overflow for non-power-of-two N. b = N - f.
  - f==0 -> reqs=010.
  - f<b -> 100.
  - f>b -> 001.
  - f==b (even N only) -> 100 if tie reg=0, else 001.
- reqs = 000 when empty. Otherwise the route is purely combinational from head and tie reg.
- reqs stays stable until the head is dequeued. The tie reg changes only on dequeue, so a waiting message never changes direction.
- Dequeue at posedge when (reqs & grants) != 0. Grant bits outside reqs are ignored. A grant while empty is ignored.
- Tie reg toggles only on dequeue of a tie-distance message.
- Simultaneous enq and deq: both occur and occupancy is unchanged. This requires a non-full FIFO, because in_rdy=0 when full.
- Pointers wrap modulo p_num_entries, which need not be a power of two. Full/empty are tracked by an occupancy count.
- num_free is registered and reflects state after the last edge.
- Dest values >= p_num_routers are illegal. Behaviour is undefined, but the block must not hang the FIFO.
- Reset asserted mid-operation discards all queued messages immediately. reqs drops to 000 asynchronously.

Optional Feature:
- Macro: PLAB4_NET_ROUTER_INPUT_UNIT_STATS_EN.
- When defined, the block adds output port stall_cycles (16 bits), a saturating counter.
- The counter increments each cycle reqs != 000 and (reqs & grants) == 0. It holds at 16'hFFFF and clears on reset.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: hold reset low 2 cycles, release, in_val=0 -> in_rdy=1, reqs=000, num_free=2 for 5 cycles.
- Greedy routing (id 2, N 8), single message each, grant every cycle:
  - dest 1 -> reqs=001; dest 2 -> 010; dest 3 -> 100; dest 5 -> 100; dest 7 -> 001.
  - Each reqs appears 1 cycle after enqueue and clears after grant.
- Tie-break: enqueue dest 6 three times, granting each -> reqs 100, then 001, then 100. Grant on a non-requested bit (grants=010) -> no dequeue, reqs unchanged.
- Full/backpressure: grants=000, send 3 messages -> first two accepted, in_rdy=0 and num_free=0 after the second, third held. Grant once -> in_rdy=1 next cycle, third accepted, FIFO order preserved on out_msg.
- Simultaneous enq/deq with 1 entry occupied: enqueue and grant same cycle -> num_free stays 1, next head is the new message.
- Async reset mid-operation: 2 queued, pulse reset low between clock edges -> reqs=000 and in_rdy=1 before next edge, num_free=2. With STATS_EN, stall_cycles=0.
